sseg_scan_ctrl: RTL and testbench

Scan controller that time-multiplexes a 16-bit hex value across the 4-digit seven-segment display. It drives the digit select and nibble inputs of the sseg4 decoder, replacing the free-running counter. It inserts a blanked dead-time between digits to prevent ghosting, and optionally blanks leading zeros. New values are accepted through a valid/ready handshake and applied atomically at frame boundaries, so a displayed number never tears.

---
 rtl/sseg_pkg.sv | 27 ++
 rtl/sseg_scan_ctrl_timer.sv | 38 +++
 rtl/sseg_scan_ctrl.sv | 99 +++++++++
 tb/tb_sseg_scan_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
//   scan_state_t : slot phase (blanked dead time, then digit shown)
//   NUM_DIGITS   : digits on the display
//   DIGIT_W      : bits per digit nibble
//   lz_mask()    : per-digit leading-zero blank mask for a 16-bit value
package sseg_pkg;

  typedef enum logic {
    DEAD = 1'b0,
    SHOW = 1'b1
  } scan_state_t;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;

  // Bit i set means digit i is a leading zero. Digit 0 is never blanked,
  // so an all-zero value still shows a single "0".
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [15:0] value);
    logic [NUM_DIGITS-1:0] mask;
    mask[3] = (value[15:12] == 4'h0);
    mask[2] = mask[3] && (value[11:8] == 4'h0);
    mask[1] = mask[2] && (value[7:4] == 4'h0);
    mask[0] = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/sseg_scan_ctrl_timer.sv
// Slot timer for the scan controller. Counts the dead-time phase and the
// show phase of each digit slot and strobes the last cycle of each phase.
//   clk, rst    : clock, synchronous active-high reset
//   en          : 0 holds the count and suppresses both strobes
//   show_phase  : 1 while the controller is in its SHOW phase
//   dead_done   : last cycle of the dead-time phase
//   show_done   : last cycle of the show phase
module scan_timer #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic show_phase,
  output logic dead_done,
  output logic show_done
);

  localparam int TW = $clog2(REFRESH_DIV);
  localparam logic [TW-1:0] DEAD_LAST = TW'(DEAD_CYCLES - 1);
  localparam logic [TW-1:0] SHOW_LAST = TW'(REFRESH_DIV - DEAD_CYCLES - 1);

  logic [TW-1:0] timer;

  assign dead_done = en && !show_phase && (timer == DEAD_LAST);
  assign show_done = en &&  show_phase && (timer == SHOW_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (en) begin
      if (dead_done || show_done) timer <= '0;
      else                        timer <= timer + 1'b1;
    end
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit seven-segment display.
// Each digit slot starts with a blanked dead time to stop ghosting, then
// shows its nibble. New values arrive over valid/ready into a pending
// register and are copied to the display register only at the frame
// boundary, so a number is never shown half old, half new.
//   clk, rst     : clock, synchronous active-high reset
//   en           : 0 freezes the scan and blanks the display
//   blank_lz     : 1 blanks leading zero digits
//   load_valid   : new value offered on load_data
//   load_data    : 16-bit value, [3:0] is the rightmost digit
//   load_ready   : a value can be accepted this cycle
//   digit_sel    : digit index to the decoder
//   digit_data   : nibble for the selected digit
//   digit_blank  : 1 turns the selected digit fully off
//   frame_done   : one-cycle pulse as the scan wraps back to digit 0
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        blank_lz,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  output logic [1:0]  digit_sel,
  output logic [3:0]  digit_data,
  output logic        digit_blank,
  output logic        frame_done
);

  scan_state_t     state;
  logic [15:0]     display;
  logic [15:0]     pending;
  logic            pending_valid;
  logic            dead_done;
  logic            show_done;
  logic            wrap;
  logic            transfer;
  logic [NUM_DIGITS-1:0] lz;

  scan_timer #(
    .REFRESH_DIV(REFRESH_DIV),
    .DEAD_CYCLES(DEAD_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .show_phase(state == SHOW),
    .dead_done (dead_done),
    .show_done (show_done)
  );

  // Frame boundary: last show cycle of the leftmost digit.
  assign wrap       = show_done && (digit_sel == 2'(NUM_DIGITS - 1));
  assign load_ready = !pending_valid;
  assign transfer   = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= DEAD;
      digit_sel     <= 2'd0;
      display       <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= wrap;

      case (state)
        DEAD: if (dead_done) state <= SHOW;
        SHOW: if (show_done) begin
          state     <= DEAD;
          digit_sel <= digit_sel + 2'd1;
        end
        default: state <= DEAD;
      endcase

      // A transfer needs pending_valid=0 and a commit needs pending_valid=1,
      // so the two never collide; a value taken on the wrap cycle waits
      // for the following boundary.
      if (wrap && pending_valid) begin
        display       <= pending;
        pending_valid <= 1'b0;
      end else if (transfer) begin
        pending       <= load_data;
        pending_valid <= 1'b1;
      end
    end
  end

  assign lz          = lz_mask(display);
  assign digit_data  = display[DIGIT_W*digit_sel +: DIGIT_W];
  assign digit_blank = !en || (state == DEAD) || (blank_lz && lz[digit_sel]);

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
module tb_sseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        blank_lz;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [1:0]  digit_sel;
  logic [3:0]  digit_data;
  logic        digit_blank;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sseg_scan_ctrl #(
    .REFRESH_DIV(8),
    .DEAD_CYCLES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .blank_lz   (blank_lz),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .digit_sel  (digit_sel),
    .digit_data (digit_data),
    .digit_blank(digit_blank),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; blank_lz = 1'b0; load_valid = 1'b0; load_data = 16'h0;
    repeat (3) step();
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", load_ready); end
    checks++; if (digit_sel !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", digit_sel); end
    checks++; if (digit_data !== 4'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", digit_data); end
    checks++; if (digit_blank !== 1'b1) begin errors++; $display("FAIL reset_blank got=%b exp=1", digit_blank); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame got=%b exp=0", frame_done); end
    rst = 1'b0; en = 1'b1;
    #1;
    cyc = 0;
  endtask

  // Slot k%8: cycles 0-1 dead, 2-7 shown; digit advances every 8 cycles.
  task automatic test_scan();
    for (int k = 0; k < 40; k++) begin
      checks++; if (digit_sel !== 2'((k / 8) % 4)) begin errors++; $display("FAIL scan_sel cyc=%0d got=%0d exp=%0d", k, digit_sel, (k / 8) % 4); end
      checks++; if (digit_blank !== ((k % 8) < 2)) begin errors++; $display("FAIL scan_blank cyc=%0d got=%b exp=%b", k, digit_blank, ((k % 8) < 2)); end
      checks++; if (frame_done !== (k == 32)) begin errors++; $display("FAIL scan_frame cyc=%0d got=%b exp=%b", k, frame_done, (k == 32)); end
      step();
    end
  endtask

  task automatic test_load_mid_frame();
    goto(45);
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL load_ready_before got=%b exp=1", load_ready); end
    load_valid = 1'b1; load_data = 16'h12AB;
    step();
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL load_ready_drop got=%b exp=0", load_ready); end
    // Second offer while a value is pending must be refused.
    load_data = 16'h5555;
    while (cyc < 50) begin
      step();
      checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL second_offer_ready cyc=%0d got=%b exp=0", cyc, load_ready); end
      checks++; if (digit_data !== 4'h0) begin errors++; $display("FAIL load_no_tear cyc=%0d got=%h exp=0", cyc, digit_data); end
    end
    load_valid = 1'b0;
    goto(63);
    checks++; if (digit_data !== 4'h0) begin errors++; $display("FAIL load_before_wrap got=%h exp=0", digit_data); end
    step();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL load_wrap_frame got=%b exp=1", frame_done); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL load_ready_return got=%b exp=1", load_ready); end
    checks++; if (digit_data !== 4'hB) begin errors++; $display("FAIL load_d0_at_wrap got=%h exp=b", digit_data); end
    goto(66);
    checks++; if (digit_data !== 4'hB || digit_blank !== 1'b0) begin errors++; $display("FAIL load_d0 got=%h/%b exp=b/0", digit_data, digit_blank); end
    goto(74);
    checks++; if (digit_data !== 4'hA || digit_blank !== 1'b0) begin errors++; $display("FAIL load_d1 got=%h/%b exp=a/0", digit_data, digit_blank); end
    goto(82);
    checks++; if (digit_data !== 4'h2) begin errors++; $display("FAIL load_d2 got=%h exp=2", digit_data); end
    goto(90);
    checks++; if (digit_data !== 4'h1) begin errors++; $display("FAIL load_d3 got=%h exp=1", digit_data); end
  endtask

  task automatic test_load_on_wrap();
    goto(95);
    checks++; if (digit_sel !== 2'd3) begin errors++; $display("FAIL wrapload_sel got=%0d exp=3", digit_sel); end
    load_valid = 1'b1; load_data = 16'h0050;
    step();
    load_valid = 1'b0;
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL wrapload_frame got=%b exp=1", frame_done); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL wrapload_ready got=%b exp=0", load_ready); end
    checks++; if (digit_data !== 4'hB) begin errors++; $display("FAIL wrapload_not_applied got=%h exp=b", digit_data); end
    goto(120);
    checks++; if (digit_data !== 4'h1) begin errors++; $display("FAIL wrapload_old_d3 got=%h exp=1", digit_data); end
    goto(128);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL wrapload_frame2 got=%b exp=1", frame_done); end
    checks++; if (digit_data !== 4'h0) begin errors++; $display("FAIL wrapload_new_d0 got=%h exp=0", digit_data); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL wrapload_ready_back got=%b exp=1", load_ready); end
  endtask

  task automatic test_blank_lz();
    blank_lz = 1'b1;
    goto(130);
    checks++; if (digit_blank !== 1'b0 || digit_data !== 4'h0) begin errors++; $display("FAIL lz50_d0 got=%b/%h exp=0/0", digit_blank, digit_data); end
    goto(138);
    checks++; if (digit_blank !== 1'b0 || digit_data !== 4'h5) begin errors++; $display("FAIL lz50_d1 got=%b/%h exp=0/5", digit_blank, digit_data); end
    goto(146);
    checks++; if (digit_blank !== 1'b1) begin errors++; $display("FAIL lz50_d2 got=%b exp=1", digit_blank); end
    goto(154);
    checks++; if (digit_blank !== 1'b1) begin errors++; $display("FAIL lz50_d3 got=%b exp=1", digit_blank); end
    goto(156);
    load_valid = 1'b1; load_data = 16'h0000;
    step();
    load_valid = 1'b0;
    goto(160);
    checks++; if (digit_blank !== 1'b1) begin errors++; $display("FAIL lz0_dead got=%b exp=1", digit_blank); end
    goto(162);
    checks++; if (digit_blank !== 1'b0 || digit_data !== 4'h0) begin errors++; $display("FAIL lz0_d0 got=%b/%h exp=0/0", digit_blank, digit_data); end
    goto(170);
    checks++; if (digit_blank !== 1'b1) begin errors++; $display("FAIL lz0_d1 got=%b exp=1", digit_blank); end
    goto(178);
    checks++; if (digit_blank !== 1'b1) begin errors++; $display("FAIL lz0_d2 got=%b exp=1", digit_blank); end
    goto(186);
    checks++; if (digit_blank !== 1'b1) begin errors++; $display("FAIL lz0_d3 got=%b exp=1", digit_blank); end
  endtask

  task automatic test_enable_hold();
    goto(188);
    blank_lz = 1'b0;
    en = 1'b0;
    #1;
    checks++; if (digit_blank !== 1'b1) begin errors++; $display("FAIL en0_blank_now got=%b exp=1", digit_blank); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (digit_blank !== 1'b1) begin errors++; $display("FAIL en0_blank i=%0d got=%b exp=1", i, digit_blank); end
      checks++; if (digit_sel !== 2'd3) begin errors++; $display("FAIL en0_sel i=%0d got=%0d exp=3", i, digit_sel); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL en0_frame i=%0d got=%b exp=0", i, frame_done); end
    end
    en = 1'b1;
    #1;
    cyc = 188;
    checks++; if (digit_blank !== 1'b0 || digit_sel !== 2'd3) begin errors++; $display("FAIL en1_resume got=%b/%0d exp=0/3", digit_blank, digit_sel); end
    goto(191);
    checks++; if (digit_sel !== 2'd3 || frame_done !== 1'b0) begin errors++; $display("FAIL en1_prewrap got=%0d/%b exp=3/0", digit_sel, frame_done); end
    step();
    checks++; if (digit_sel !== 2'd0 || frame_done !== 1'b1) begin errors++; $display("FAIL en1_wrap got=%0d/%b exp=0/1", digit_sel, frame_done); end
  endtask

  task automatic test_reset_pending();
    load_valid = 1'b1; load_data = 16'h4321;
    step();
    load_valid = 1'b0;
    goto(226);
    checks++; if (digit_data !== 4'h1) begin errors++; $display("FAIL rstp_shown got=%h exp=1", digit_data); end
    load_valid = 1'b1; load_data = 16'hBEEF;
    step();
    load_valid = 1'b0;
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL rstp_pending got=%b exp=0", load_ready); end
    rst = 1'b1;
    step();
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rstp_ready got=%b exp=1", load_ready); end
    checks++; if (digit_sel !== 2'd0) begin errors++; $display("FAIL rstp_sel got=%0d exp=0", digit_sel); end
    checks++; if (digit_data !== 4'h0) begin errors++; $display("FAIL rstp_data got=%h exp=0", digit_data); end
    checks++; if (digit_blank !== 1'b1) begin errors++; $display("FAIL rstp_blank got=%b exp=1", digit_blank); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rstp_frame got=%b exp=0", frame_done); end
    rst = 1'b0;
    cyc = 0;
    goto(32);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL rstp_wrap got=%b exp=1", frame_done); end
    checks++; if (digit_data !== 4'h0) begin errors++; $display("FAIL rstp_discard_d0 got=%h exp=0", digit_data); end
    goto(42);
    checks++; if (digit_data !== 4'h0) begin errors++; $display("FAIL rstp_discard_d1 got=%h exp=0", digit_data); end
    goto(58);
    checks++; if (digit_data !== 4'h0) begin errors++; $display("FAIL rstp_discard_d3 got=%h exp=0", digit_data); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_mid_frame();
    test_load_on_wrap();
    test_blank_lz();
    test_enable_hold();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
